// File: rtl/booth_div.sv
// booth_div: sequential radix-2 restoring divider, WIDTH-bit quotient and remainder.
// Latency: done pulses WIDTH+1 clocks after the accepting edge, regardless of operands.
// Backpressure: start is sampled only while idle; requests during busy are dropped.
// Optional build macro BOOTH_DIV_SIGNED_EN selects two's complement operands.
module booth_div #(
  parameter int WIDTH = 224
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] pr;      // partial remainder
  logic [WIDTH-1:0] quo;     // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0] dsr;     // divisor magnitude
  logic [CW-1:0]    count;
  logic             dz;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             ge;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;

`ifdef BOOTH_DIV_SIGNED_EN
  logic sgn_a;
  logic sgn_b;

  // The core divides magnitudes; -2^(WIDTH-1) maps to 2^(WIDTH-1), still representable unsigned.
  always_comb begin
    mag_a = a[WIDTH-1] ? -a : a;
    mag_b = b[WIDTH-1] ? -b : b;
  end
`else
  // Unsigned operands feed the core directly.
  always_comb begin
    mag_a = a;
    mag_b = b;
  end
`endif

  // One restoring step: shift in the next dividend bit, trial-subtract the divisor.
  // When the trial succeeds the difference is below the divisor, so WIDTH bits suffice.
  always_comb begin
    shifted = {pr, quo[WIDTH-1]};
    ge      = shifted >= {1'b0, dsr};
    diff    = shifted[WIDTH-1:0] - dsr;
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CALC;
      CALC:    if (count == '0) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath and registered handshake outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      q           <= '0;
      r           <= '0;
      div_by_zero <= 1'b0;
      pr          <= '0;
      quo         <= '0;
      dsr         <= '0;
      count       <= '0;
      dz          <= 1'b0;
`ifdef BOOTH_DIV_SIGNED_EN
      sgn_a       <= 1'b0;
      sgn_b       <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            pr    <= '0;
            quo   <= mag_a;
            dsr   <= mag_b;
            dz    <= (b == '0);
            count <= CW'(WIDTH - 1);
            busy  <= 1'b1;
`ifdef BOOTH_DIV_SIGNED_EN
            sgn_a <= a[WIDTH-1];
            sgn_b <= b[WIDTH-1];
`endif
          end
        end
        CALC: begin
          pr    <= ge ? diff : shifted[WIDTH-1:0];
          quo   <= {quo[WIDTH-2:0], ge};
          count <= count - 1'b1;
        end
        FIX: begin
          // A zero divisor makes every trial succeed: quotient all ones, remainder = |a|.
`ifdef BOOTH_DIV_SIGNED_EN
          q <= dz ? '1 : ((sgn_a ^ sgn_b) ? -quo : quo);
          r <= sgn_a ? -pr : pr;
`else
          q <= quo;
          r <= pr;
`endif
          div_by_zero <= dz;
          done        <= 1'b1;
          busy        <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_div.sv
// tb_booth_div: scoreboard bench for booth_div with a plain-arithmetic reference model.
// Stimulus pushes expected results; a negedge monitor pops and compares on every done.
// Directed corner cases plus randomized operands; both builds of the divider are modelled.
module tb_booth_div;
  localparam int W = 224;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] q;
  logic [W-1:0] r;
  logic         div_by_zero;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    int           due;
  } exp_t;

  exp_t sb[$];

  booth_div #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .q(q), .r(r), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: truncating division on magnitudes, quotient sign = XOR, remainder sign = dividend.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input int due);
    exp_t e;
    logic [W-1:0] mx, my, qm, rm;
    logic sx, sy;
    e.due = due;
    e.dz  = (y == '0);
`ifdef BOOTH_DIV_SIGNED_EN
    sx = x[W-1];
    sy = y[W-1];
`else
    sx = 1'b0;
    sy = 1'b0;
`endif
    mx = sx ? -x : x;
    my = sy ? -y : y;
    if (y == '0) begin
      e.q = '1;
      e.r = x;
    end else begin
      qm  = mx / my;
      rm  = mx % my;
      e.q = (sx ^ sy) ? -qm : qm;
      e.r = sx ? -rm : rm;
    end
    return e;
  endfunction

  function automatic logic [W-1:0] rnd();
    logic [W-1:0] v = '0;
    for (int i = 0; i < (W + 31) / 32; i++) v = (v << 32) | W'($urandom);
    return v;
  endfunction

  // Monitor: every done must match the oldest expectation, on its due cycle; busy high meanwhile.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst) begin
      if (done) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done at cycle %0d got q=%h", cyc, q);
        end else begin
          e = sb.pop_front();
          chk("q", q, e.q);
          chk("r", r, e.r);
          chk("div_by_zero", W'(div_by_zero), W'(e.dz));
          chk("done_cycle", W'(cyc), W'(e.due));
          chk("busy_at_done", W'(busy), W'(0));
        end
      end else if (sb.size() > 0 && cyc < sb[0].due) begin
        chk("busy_during_op", W'(busy), W'(1));
      end
    end
  end

  // Call at a negedge with the DUT idle; returns just after the accepting edge.
  task automatic issue_now(input logic [W-1:0] x, input logic [W-1:0] y);
    start = 1'b1;
    a = x;
    b = y;
    @(posedge clk);
    #1;
    sb.push_back(model(x, y, cyc + W + 1));
    start = 1'b0;
    a = ~x;
    b = rnd();
  endtask

  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clk);
    issue_now(x, y);
  endtask

  task automatic wait_empty();
    for (int i = 0; i < W + 60 && sb.size() > 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL timeout pending %0d expected results", sb.size());
      sb.delete();
    end
  endtask

  task automatic run(input logic [W-1:0] x, input logic [W-1:0] y);
    issue(x, y);
    wait_empty();
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [W-1:0] x, y, one;
    int seen;
    one = W'(1);

    #1;
    chk("rst_busy", W'(busy), W'(0));
    chk("rst_done", W'(done), W'(0));
    chk("rst_q", q, '0);
    chk("rst_r", r, '0);
    chk("rst_dz", W'(div_by_zero), W'(0));
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // Directed corners.
    run(W'(100), W'(7));
    run(W'(5), '0);
    run('1, '1);
    run(W'(3), one << (W - 1));
`ifdef BOOTH_DIV_SIGNED_EN
    run(-W'(100), W'(7));
    run(W'(100), -W'(7));
    run(one << (W - 1), '1);
`endif

    // Start pulsed mid-operation is ignored.
    issue(W'(1000), W'(33));
    repeat (49) @(negedge clk);
    start = 1'b1;
    a = W'(77);
    b = W'(2);
    @(negedge clk);
    start = 1'b0;
    wait_empty();

    // Back-to-back: start in the done cycle is accepted.
    issue(W'(999), W'(10));
    seen = 0;
    for (int i = 0; i < W + 40 && seen == 0; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    checks++;
    if (seen == 0) begin
      errors++;
      $display("FAIL b2b_first_done got none expected one");
    end else begin
      issue_now(W'(12345), W'(11));
    end
    wait_empty();

    // Randomized operands.
    for (int n = 0; n < 20; n++) begin
      x = rnd();
      case ($urandom_range(0, 3))
        0: y = rnd();
        1: y = W'($urandom_range(1, 1000));
        2: y = rnd() >> $urandom_range(0, W - 1);
        default: y = ($urandom_range(0, 1) == 0) ? '0 : rnd() >> 100;
      endcase
      if ($urandom_range(0, 3) == 0) x = x >> $urandom_range(0, W - 1);
      run(x, y);
    end

    // Asynchronous reset mid-operation.
    issue(W'(54321), W'(9));
    repeat (100) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_busy", W'(busy), W'(0));
    chk("arst_done", W'(done), W'(0));
    chk("arst_q", q, '0);
    chk("arst_r", r, '0);
    chk("arst_dz", W'(div_by_zero), W'(0));
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    seen = 0;
    for (int i = 0; i < W + 40; i++) begin
      @(negedge clk);
      if (done) seen++;
    end
    chk("no_done_after_reset", W'(seen), W'(0));

    run(W'(200), W'(7));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
